branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Parametrised branch resolution unit for the decode stage of the pipelined RV32 core. It evaluates all six RV32I conditional-branch conditions on forwarded operands and checks the outcome against the fetch-time prediction. It maintains a 2-bit-counter branch history table (BHT) that fetch queries. On a mispredict it issues a registered redirect, and it keeps saturating branch and mispredict statistics counters.

## Interface

- XLEN, 32, datapath and PC width
- BHT_ENTRIES, 64, number of BHT counters; power of two, at least 2
- IDX_LSB, 2, lowest PC bit used for the BHT index
- CNT_W, 32, width of the statistics counters
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset
- if_pc  in  XLEN  fetch PC for prediction lookup
- if_pred_taken  out  1  combinational prediction: MSB of the BHT counter indexed by if_pc
- id_valid  in  1  decode-stage instruction valid
- id_stall  in  1  decode-stage stall; no resolution while high
- id_is_branch  in  1  decode instruction is a conditional branch
- id_funct3  in  3  branch condition
- id_pc, id_imm  in  XLEN  branch PC and sign-extended B-immediate
- id_pred_taken  in  1  prediction carried down from fetch
- rdata1, rdata2  in  XLEN  register-file operands
- fwd_a, fwd_b  in  2  forwarding selects for the two operands
- mem_alu  in  XLEN  MEM-stage ALU result
- wb_dmem, wb_alu, wb_pc  in  XLEN  WB-stage sources
- wb_sel  in  2  WB source select
- redirect_valid  out  1  registered mispredict redirect; reset 0
- redirect_pc  out  XLEN  registered redirect target; reset 0
- resolved_taken  out  1  registered actual outcome of the last resolved branch; reset 0
- illegal_cond  out  1  registered pulse for funct3 010 or 011; reset 0
- branch_cnt, mispred_cnt  out  CNT_W  saturating statistics; reset 0

## Operation

- WB data:
  - wb_sel 00 selects wb_dmem.
  - wb_sel 01 selects wb_alu.
  - wb_sel 10 or 11 selects wb_pc+4, truncated to XLEN.
- Operand A:
  - fwd_a[1] set selects mem_alu.
  - Otherwise fwd_a[0] set selects WB data.
  - Otherwise selects rdata1.
  - Operand B is selected the same way from fwd_b and rdata2.
- Branch conditions by funct3:
  - 000 BEQ, 001 BNE.
  - 100 BLT and 101 BGE, signed compare.
  - 110 BLTU and 111 BGEU, unsigned compare.
  - 010 and 011 are treated as not taken and pulse illegal_cond.
- A resolve event occurs when id_valid, id_is_branch and !id_stall are all high and redirect_valid is low.
  - The redirect_valid condition is the shadow rule: the decode slot right after a redirect holds a wrong-path instruction and is ignored entirely.
- Mispredict means taken != id_pred_taken.
- On a resolve event, at the next edge:
  - resolved_taken is loaded with the outcome.
  - branch_cnt increments.
  - On a mispredict: redirect_valid goes to 1, redirect_pc is loaded, and mispred_cnt increments.
  - redirect_pc is id_pc+id_imm if taken, otherwise id_pc+4. Both sums wrap modulo 2^XLEN.
- redirect_valid is a one-cycle pulse. It clears on the following edge whatever the inputs are.
- The statistics counters saturate at all-ones and never wrap.
- BHT index is pc[IDX_LSB+log2(BHT_ENTRIES)-1 : IDX_LSB].
- BHT update on a resolve event:
  - Taken increments the indexed counter, saturating at 11.
  - Not taken decrements it, saturating at 00.
  - illegal_cond events also update the BHT, as not taken.
- Reset:
  - All BHT counters go to 01 (weakly not taken).
  - All outputs go to 0.
  - Any in-flight redirect is dropped.

## Timing

- Compare and forwarding are combinational in the decode cycle. Results are registered with a latency of 1 cycle.
- BHT read and write ordering:
  - The BHT write occurs at the resolve edge.
  - if_pred_taken in the same cycle as a write to the same index returns the old value.
  - The new value is visible from the next cycle.
- While id_stall is high, no state changes except the auto-clear of redirect_valid.
- Back-to-back resolve events on consecutive cycles are accepted when no redirect is pending. The counters then increment once per cycle.
- rst_n sampled low overrides every simultaneous event.

## Test plan

- Reset, then sweep if_pc over 0x0–0xFC → if_pred_taken=0 for all; all outputs 0.
- BEQ with a=b=5, id_pc=0x100, id_imm=0x20, pred 0 → one cycle later redirect_valid=1 and redirect_pc=0x120, then 0 the following cycle; mispred_cnt=1; if_pred_taken for 0x100 becomes 1.
- a=0xFFFFFFFF, b=1:
  - BLT → taken.
  - BLTU → not taken; with pred 1, redirect_pc=id_pc+4.
  - BGE/BGEU give the complementary results.
- Forwarding:
  - fwd_a=11 selects mem_alu=7.
  - fwd_b=01 with wb_sel=10 and wb_pc=3 (WB data 7) → BEQ taken.
  - fwd_b=00 selects rdata2.
- Same PC resolved taken 4 times → counter saturates at 11. One not-taken → 10, prediction still 1. id_pc=0xFFFFFFFC, imm=8 → redirect_pc=0x4.
- Shadow, stall and reset cases:
  - Mispredict followed next cycle by a valid branch → second branch ignored, branch_cnt unchanged.
  - id_stall=1 → no update.
  - rst_n low on the cycle a redirect would issue → redirect_valid stays 0.
  - Preset mispred_cnt to all-ones, then mispredict → count stays all-ones.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: decode-stage resolver for RV32I conditional branches.
// Selects forwarded operands, evaluates the branch condition, compares with
// the fetch-time prediction, keeps a 2-bit-counter BHT for fetch, issues a
// registered one-cycle redirect on mispredict and keeps saturating stats.
//
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_if_pc                  fetch PC for BHT lookup
//   o_if_pred_taken          combinational prediction (BHT counter MSB)
//   i_id_*                   decode-stage branch: valid, stall, is_branch,
//                            funct3, pc, imm, pred_taken
//   i_rdata1/2, i_fwd_a/b    register operands and forwarding selects
//   i_mem_alu, i_wb_*        forwarding sources, i_wb_sel picks WB data
//   o_redirect_valid/pc      registered mispredict redirect
//   o_resolved_taken         outcome of the last resolved branch
//   o_illegal_cond           pulse for reserved funct3 010/011
//   o_branch_cnt/mispred_cnt saturating statistics
module branch_resolve_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned IDX_LSB     = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [XLEN-1:0]  i_if_pc,
  output logic             o_if_pred_taken,
  input  logic             i_id_valid,
  input  logic             i_id_stall,
  input  logic             i_id_is_branch,
  input  logic [2:0]       i_id_funct3,
  input  logic [XLEN-1:0]  i_id_pc,
  input  logic [XLEN-1:0]  i_id_imm,
  input  logic             i_id_pred_taken,
  input  logic [XLEN-1:0]  i_rdata1,
  input  logic [XLEN-1:0]  i_rdata2,
  input  logic [1:0]       i_fwd_a,
  input  logic [1:0]       i_fwd_b,
  input  logic [XLEN-1:0]  i_mem_alu,
  input  logic [XLEN-1:0]  i_wb_dmem,
  input  logic [XLEN-1:0]  i_wb_alu,
  input  logic [XLEN-1:0]  i_wb_pc,
  input  logic [1:0]       i_wb_sel,
  output logic             o_redirect_valid,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_resolved_taken,
  output logic             o_illegal_cond,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

  logic [1:0]      r_bht [BHT_ENTRIES];
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_resolved_taken;
  logic            r_illegal_cond;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic [XLEN-1:0] w_wb_data;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic            w_taken;
  logic            w_illegal;
  logic            w_resolve;
  logic            w_mispred;
  logic [XLEN-1:0] w_target;
  logic [IdxW-1:0] w_if_idx;
  logic [IdxW-1:0] w_id_idx;
  logic [1:0]      w_bht_cur;
  logic [1:0]      w_bht_next;
  logic            w_unused_pc;

  // Only the index bits of the PCs feed the BHT; the rest is deliberately dropped.
  assign w_unused_pc = ^{i_if_pc, i_id_pc};

  assign w_if_idx        = i_if_pc[IDX_LSB +: IdxW];
  assign w_id_idx        = i_id_pc[IDX_LSB +: IdxW];
  assign o_if_pred_taken = r_bht[w_if_idx][1];

  always_comb begin
    unique case (i_wb_sel)
      2'b00:   w_wb_data = i_wb_dmem;
      2'b01:   w_wb_data = i_wb_alu;
      default: w_wb_data = i_wb_pc + XLEN'(4);
    endcase
  end

  // MEM has priority over WB: it holds the younger producer.
  assign w_op_a = i_fwd_a[1] ? i_mem_alu : (i_fwd_a[0] ? w_wb_data : i_rdata1);
  assign w_op_b = i_fwd_b[1] ? i_mem_alu : (i_fwd_b[0] ? w_wb_data : i_rdata2);

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    unique case (i_id_funct3)
      3'b000:  w_taken = (w_op_a == w_op_b);
      3'b001:  w_taken = (w_op_a != w_op_b);
      3'b100:  w_taken = ($signed(w_op_a) <  $signed(w_op_b));
      3'b101:  w_taken = ($signed(w_op_a) >= $signed(w_op_b));
      3'b110:  w_taken = (w_op_a <  w_op_b);
      3'b111:  w_taken = (w_op_a >= w_op_b);
      default: w_illegal = 1'b1;
    endcase
  end

  // The slot after a redirect is wrong-path, so a pending redirect blocks resolution.
  assign w_resolve = i_id_valid & i_id_is_branch & ~i_id_stall & ~r_redirect_valid;
  assign w_mispred = (w_taken != i_id_pred_taken);
  assign w_target  = w_taken ? (i_id_pc + i_id_imm) : (i_id_pc + XLEN'(4));

  assign w_bht_cur = r_bht[w_id_idx];
  always_comb begin
    w_bht_next = w_bht_cur;
    if (w_taken) begin
      if (w_bht_cur != 2'b11) w_bht_next = w_bht_cur + 2'b01;
    end else begin
      if (w_bht_cur != 2'b00) w_bht_next = w_bht_cur - 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_resolved_taken <= 1'b0;
      r_illegal_cond   <= 1'b0;
      r_branch_cnt     <= '0;
      r_mispred_cnt    <= '0;
    end else begin
      r_redirect_valid <= 1'b0;
      r_illegal_cond   <= 1'b0;
      if (w_resolve) begin
        r_bht[w_id_idx]  <= w_bht_next;
        r_resolved_taken <= w_taken;
        r_illegal_cond   <= w_illegal;
        if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
        if (w_mispred) begin
          r_redirect_valid <= 1'b1;
          r_redirect_pc    <= w_target;
          if (r_mispred_cnt != '1) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_resolved_taken = r_resolved_taken;
  assign o_illegal_cond   = r_illegal_cond;
  assign o_branch_cnt     = r_branch_cnt;
  assign o_mispred_cnt    = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboarded testbench for branch_resolve_unit. The driver applies one set
// of inputs per cycle, runs a reference model and queues the expected
// registered outputs; a monitor pops and compares them after every rising edge.
module tb_branch_resolve_unit;

  localparam int unsigned CntW   = 7;
  localparam int          CntMax = (1 << CntW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        id_valid, id_stall, id_is_branch, id_pred_taken;
  logic [2:0]  id_funct3;
  logic [31:0] id_pc, id_imm, rdata1, rdata2, mem_alu, wb_dmem, wb_alu, wb_pc;
  logic [1:0]  fwd_a, fwd_b, wb_sel;
  logic        redirect_valid, resolved_taken, illegal_cond;
  logic [31:0] redirect_pc;
  logic [CntW-1:0] branch_cnt, mispred_cnt;

  branch_resolve_unit #(
    .XLEN(32), .BHT_ENTRIES(64), .IDX_LSB(2), .CNT_W(CntW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_if_pc(if_pc), .o_if_pred_taken(if_pred_taken),
    .i_id_valid(id_valid), .i_id_stall(id_stall), .i_id_is_branch(id_is_branch),
    .i_id_funct3(id_funct3), .i_id_pc(id_pc), .i_id_imm(id_imm),
    .i_id_pred_taken(id_pred_taken), .i_rdata1(rdata1), .i_rdata2(rdata2),
    .i_fwd_a(fwd_a), .i_fwd_b(fwd_b), .i_mem_alu(mem_alu), .i_wb_dmem(wb_dmem),
    .i_wb_alu(wb_alu), .i_wb_pc(wb_pc), .i_wb_sel(wb_sel),
    .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
    .o_resolved_taken(resolved_taken), .o_illegal_cond(illegal_cond),
    .o_branch_cnt(branch_cnt), .o_mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rv;
    logic [31:0] rpc;
    bit          rt;
    bit          ill;
    int          bc;
    int          mc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_bht[64];
  bit          m_redir;
  logic [31:0] m_rpc;
  bit          m_rt, m_ill;
  int          m_bc, m_mc;

  function automatic int bht_idx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic logic [31:0] pick_operand(input logic [31:0] wbd, input logic [1:0] sel,
                                               input logic [31:0] rf);
    if (sel >= 2) return mem_alu;
    if (sel == 1) return wbd;
    return rf;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Called just after a falling edge with inputs applied: checks the
  // combinational prediction, advances the model across the next rising edge.
  task automatic step();
    exp_t        e;
    logic [31:0] wbd, a, b;
    bit          tk, ill, pend;
    int          k;
    #1;
    check_bit("if_pred_taken", if_pred_taken, m_bht[bht_idx(if_pc)] >= 2);
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      m_redir = 0; m_rpc = 0; m_rt = 0; m_ill = 0; m_bc = 0; m_mc = 0;
    end else begin
      pend    = m_redir;
      m_redir = 0;
      m_ill   = 0;
      if (id_valid && id_is_branch && !id_stall && !pend) begin
        if (wb_sel == 0)      wbd = wb_dmem;
        else if (wb_sel == 1) wbd = wb_alu;
        else                  wbd = wb_pc + 32'd4;
        a   = pick_operand(wbd, fwd_a, rdata1);
        b   = pick_operand(wbd, fwd_b, rdata2);
        ill = 0;
        case (id_funct3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = !($signed(a) < $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = !(a < b);
          default: begin tk = 0; ill = 1; end
        endcase
        m_rt  = tk;
        m_ill = ill;
        if (m_bc < CntMax) m_bc++;
        if (tk != id_pred_taken) begin
          m_redir = 1;
          m_rpc   = tk ? id_pc + id_imm : id_pc + 32'd4;
          if (m_mc < CntMax) m_mc++;
        end
        k = bht_idx(id_pc);
        if (tk) m_bht[k] = (m_bht[k] < 3) ? m_bht[k] + 1 : 3;
        else    m_bht[k] = (m_bht[k] > 0) ? m_bht[k] - 1 : 0;
      end
    end
    e.rv = m_redir; e.rpc = m_rpc; e.rt = m_rt; e.ill = m_ill; e.bc = m_bc; e.mc = m_mc;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] fpc);
    id_valid = 0;
    id_stall = 0;
    if_pc    = fpc;
    step();
  endtask

  task automatic branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                        input logic pred, input logic [31:0] r1, input logic [31:0] r2);
    id_valid = 1; id_is_branch = 1; id_stall = 0;
    id_funct3 = f3; id_pc = pc; id_imm = imm; id_pred_taken = pred;
    rdata1 = r1; rdata2 = r2; fwd_a = 0; fwd_b = 0;
    step();
  endtask

  // Monitor: one expected record per clock edge once the driver has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_bit("redirect_valid", redirect_valid, e.rv);
        check_word("redirect_pc", redirect_pc, e.rpc);
        check_bit("resolved_taken", resolved_taken, e.rt);
        check_bit("illegal_cond", illegal_cond, e.ill);
        check_word("branch_cnt", 32'(branch_cnt), e.bc);
        check_word("mispred_cnt", 32'(mispred_cnt), e.mc);
      end
    end
  end

  logic [31:0] pool [8];

  initial begin
    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'h5; pool[3] = 32'h7;
    pool[4] = 32'hFFFF_FFFF; pool[5] = 32'h8000_0000; pool[6] = 32'h7FFF_FFFF; pool[7] = 32'h3;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    rst_n = 0; if_pc = 0; id_valid = 0; id_stall = 0; id_is_branch = 0; id_pred_taken = 0;
    id_funct3 = 0; id_pc = 0; id_imm = 0; rdata1 = 0; rdata2 = 0; fwd_a = 0; fwd_b = 0;
    mem_alu = 0; wb_dmem = 0; wb_alu = 0; wb_pc = 0; wb_sel = 0;
    m_redir = 0; m_rpc = 0; m_rt = 0; m_ill = 0; m_bc = 0; m_mc = 0;
    @(negedge clk);
    step();
    step();
    rst_n = 1;
    // Prediction sweep after reset: every counter weakly not taken.
    for (int p = 0; p <= 32'hFC; p += 4) idle(32'(p));

    // BEQ taken, predicted not taken: redirect to 0x120, BHT 0x100 -> 10.
    branch(3'd0, 32'h100, 32'h20, 1'b0, 32'd5, 32'd5);
    idle(32'h100);
    idle(32'h100);

    // Signed vs unsigned with a=-1, b=1.
    branch(3'd4, 32'h200, 32'h40, 1'b1, 32'hFFFF_FFFF, 32'd1);
    branch(3'd6, 32'h204, 32'h40, 1'b1, 32'hFFFF_FFFF, 32'd1);
    idle(32'h204);
    branch(3'd5, 32'h208, 32'h40, 1'b0, 32'hFFFF_FFFF, 32'd1);
    branch(3'd7, 32'h20C, 32'h40, 1'b0, 32'hFFFF_FFFF, 32'd1);
    idle(32'h20C);

    // Forwarding: MEM on A, WB pc+4 on B, both 7.
    mem_alu = 32'd7; wb_sel = 2'b10; wb_pc = 32'd3;
    id_valid = 1; id_is_branch = 1; id_stall = 0; id_funct3 = 0; id_pc = 32'h210;
    id_imm = 32'h10; id_pred_taken = 0; rdata1 = 32'd1; rdata2 = 32'd2;
    fwd_a = 2'b11; fwd_b = 2'b01;
    step();
    idle(32'h210);
    fwd_b = 2'b00; rdata2 = 32'd7;
    step();
    idle(32'h210);

    // Saturate one counter with back-to-back taken branches, then one not-taken.
    for (int i = 0; i < 4; i++) branch(3'd0, 32'h300, 32'h8, 1'b1, 32'd9, 32'd9);
    branch(3'd1, 32'h300, 32'h8, 1'b1, 32'd9, 32'd9);
    idle(32'h300);
    // Wrapping target.
    branch(3'd0, 32'hFFFF_FFFC, 32'h8, 1'b0, 32'd1, 32'd1);
    idle(32'h0);

    // Shadow slot ignored, stall ignored, illegal funct3.
    branch(3'd1, 32'h400, 32'h8, 1'b0, 32'd1, 32'd2);
    branch(3'd0, 32'h404, 32'h8, 1'b0, 32'd1, 32'd1);
    id_stall = 1;
    step();
    branch(3'd2, 32'h408, 32'h8, 1'b1, 32'd1, 32'd1);
    idle(32'h408);

    // Randomised traffic; long enough that both counters saturate.
    for (int n = 0; n < 1500; n++) begin
      id_valid      = ($urandom_range(0, 9) < 8);
      id_is_branch  = ($urandom_range(0, 9) < 8);
      id_stall      = ($urandom_range(0, 9) < 2);
      id_funct3     = 3'($urandom_range(0, 7));
      id_pc         = {22'h0, 6'($urandom_range(0, 15)), 4'h0};
      if ($urandom_range(0, 19) == 0) id_pc = 32'hFFFF_FFF0 | (id_pc & 32'hC);
      id_imm        = {$urandom} & 32'hFFFF_FFFE;
      id_pred_taken = 1'($urandom_range(0, 1));
      rdata1        = $urandom_range(0, 1) ? pool[$urandom_range(0, 7)] : $urandom;
      rdata2        = $urandom_range(0, 1) ? pool[$urandom_range(0, 7)] : $urandom;
      mem_alu       = pool[$urandom_range(0, 7)];
      wb_dmem       = pool[$urandom_range(0, 7)];
      wb_alu        = pool[$urandom_range(0, 7)];
      wb_pc         = pool[$urandom_range(0, 7)];
      wb_sel        = 2'($urandom_range(0, 3));
      fwd_a         = 2'($urandom_range(0, 3));
      fwd_b         = 2'($urandom_range(0, 3));
      if_pc         = {22'h0, 6'($urandom_range(0, 15)), 4'h0};
      step();
    end

    // Reset asserted in the cycle a mispredict would redirect.
    rst_n = 0;
    branch(3'd0, 32'h500, 32'h8, 1'b0, 32'd4, 32'd4);
    rst_n = 1;
    idle(32'h500);
    idle(32'h500);

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
